// File: rtl/axi4lite_regbank.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_regbank
// Desc     : Parametrised AXI4-Lite slave register bank. Word-aligned
//            registers with byte strobes, AW/W accepted in either order,
//            optional read-only status registers sourced from reg_in, and
//            SLVERR for out-of-range or read-only writes.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_regbank #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 4,
    parameter int                  NUM_REGS           = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int         c_dw       = C_S_AXI_DATA_WIDTH;
    localparam int         c_strb_w   = c_dw / 8;
    localparam int         c_addr_lsb = $clog2(c_strb_w);
    localparam int         c_idx_w    = C_S_AXI_ADDR_WIDTH - c_addr_lsb;
    localparam logic [1:0] c_okay     = 2'b00;
    localparam logic [1:0] c_slverr   = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wstate_t               wstate_q, wstate_d;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [c_idx_w-1:0]    awidx_q;
    logic [c_dw-1:0]       wdata_q;
    logic [c_strb_w-1:0]   wstrb_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    logic                  w_aw_hs, w_w_hs, w_commit, w_wr_ok;
    logic [c_idx_w-1:0]    w_widx;
    logic [c_dw-1:0]       w_wdata;
    logic [c_strb_w-1:0]   w_wstrb;
    logic [NUM_REGS-1:0]   w_wsel;

    assign w_aw_hs = S_AXI_AWVALID && awready_q;
    assign w_w_hs  = S_AXI_WVALID && wready_q;

    // A handshake on the commit edge itself supplies its fields live; otherwise use the latched copy
    assign w_widx  = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_addr_lsb] : awidx_q;
    assign w_wdata = w_w_hs ? S_AXI_WDATA : wdata_q;
    assign w_wstrb = w_w_hs ? S_AXI_WSTRB : wstrb_q;

    // Write FSM next state plus commit decode (register index one-hot, RO registers excluded later)
    always_comb begin
        wstate_d = wstate_q;
        w_wsel   = '0;
        case (wstate_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) wstate_d = W_RESP;
                else if (w_aw_hs)      wstate_d = W_HAVE_AW;
                else if (w_w_hs)       wstate_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)       wstate_d = W_RESP;
            W_HAVE_W:  if (w_aw_hs)      wstate_d = W_RESP;
            W_RESP:    if (S_AXI_BREADY) wstate_d = W_IDLE;
            default:                     wstate_d = W_IDLE;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wsel[i] = (w_widx == c_idx_w'(i));
        end
    end

    assign w_commit = (wstate_d == W_RESP) && (wstate_q != W_RESP);
    assign w_wr_ok  = |(w_wsel & ~RO_MASK);

    // Write FSM state, registered handshake outputs, AW/W holding registers and write pulses
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= c_okay;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            awready_q  <= (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
            wready_q   <= (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
            bvalid_q   <= (wstate_d == W_RESP);
            wr_pulse_q <= w_commit ? (w_wsel & ~RO_MASK) : '0;
            if (w_commit) begin
                bresp_q <= w_wr_ok ? c_okay : c_slverr;
            end
            if (w_aw_hs) begin
                awidx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_addr_lsb];
            end
            if (w_w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign wr_pulse      = wr_pulse_q;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [c_dw-1:0] w_rd_val [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            assign reg_out[gi*c_dw +: c_dw] = '0;
            assign w_rd_val[gi]             = reg_in[gi*c_dw +: c_dw];
        end else begin : g_rw
            logic [c_dw-1:0] reg_q;
            logic            w_unused_in;

            // Byte-lane update on the commit edge; strobe-less writes leave the value untouched
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    reg_q <= '0;
                end else if (w_commit && w_wsel[gi]) begin
                    for (int k = 0; k < c_strb_w; k++) begin
                        if (w_wstrb[k]) begin
                            reg_q[8*k +: 8] <= w_wdata[8*k +: 8];
                        end
                    end
                end
            end

            assign reg_out[gi*c_dw +: c_dw] = reg_q;
            assign w_rd_val[gi]             = reg_q;
            assign w_unused_in              = ^reg_in[gi*c_dw +: c_dw];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t            rstate_q, rstate_d;
    logic               arready_q, rvalid_q;
    logic [c_dw-1:0]    rdata_q;
    logic [1:0]         rresp_q;

    logic               w_ar_hs, w_rhit;
    logic [c_idx_w-1:0] w_ridx;
    logic [c_dw-1:0]    w_rdata;

    assign w_ar_hs = S_AXI_ARVALID && arready_q;
    assign w_ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_addr_lsb];

    // Read FSM next state and read-data mux; out-of-range indices return zero
    always_comb begin
        rstate_d = rstate_q;
        w_rdata  = '0;
        w_rhit   = 1'b0;
        case (rstate_q)
            R_IDLE:  if (w_ar_hs)      rstate_d = R_VALID;
            R_VALID: if (S_AXI_RREADY) rstate_d = R_IDLE;
            default:                   rstate_d = R_IDLE;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ridx == c_idx_w'(i)) begin
                w_rdata = w_rd_val[i];
                w_rhit  = 1'b1;
            end
        end
    end

    // Read FSM state and registered R channel, captured on the AR handshake edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= c_okay;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= (rstate_d == R_IDLE);
            rvalid_q  <= (rstate_d == R_VALID);
            if (w_ar_hs) begin
                rdata_q <= w_rdata;
                rresp_q <= w_rhit ? c_okay : c_slverr;
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // Protection bits and byte-offset address bits carry no meaning here
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[c_addr_lsb-1:0], S_AXI_ARADDR[c_addr_lsb-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_regbank
// Desc     : Self-checking bench for axi4lite_regbank (4 x 32-bit registers,
//            5-bit address, register 3 read-only) with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_regbank;

    localparam int         c_dw  = 32;
    localparam int         c_aw  = 5;
    localparam int         c_nr  = 4;
    localparam logic [3:0] c_ro  = 4'b1000;

    logic                 clk;
    logic                 rst_n;
    logic [c_aw-1:0]      awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [c_dw-1:0]      wdata;
    logic [c_dw/8-1:0]    wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [c_aw-1:0]      araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [c_dw-1:0]      rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic [c_nr*c_dw-1:0] reg_out;
    logic [c_nr*c_dw-1:0] reg_in;
    logic [c_nr-1:0]      wr_pulse;

    int checks;
    int errors;
    int cycle_cnt;

    logic [31:0] model [c_nr];

    axi4lite_regbank #(
        .C_S_AXI_DATA_WIDTH(c_dw),
        .C_S_AXI_ADDR_WIDTH(c_aw),
        .NUM_REGS          (c_nr),
        .RO_MASK           (c_ro)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .reg_out      (reg_out),
        .reg_in       (reg_in),
        .wr_pulse     (wr_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    // Expected reg_out: model contents, read-only slices forced to zero
    function automatic logic [c_nr*c_dw-1:0] exp_out();
        logic [c_nr*c_dw-1:0] v;
        v = '0;
        for (int i = 0; i < c_nr; i++) begin
            if (!c_ro[i]) v[i*c_dw +: c_dw] = model[i];
        end
        return v;
    endfunction

    function automatic bit writable(input int idx);
        bit ok;
        ok = 1'b0;
        if (idx < c_nr) ok = !c_ro[idx];
        return ok;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_txn(input logic [c_aw-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        int          cyc;
        int          idx;
        bit          aw_done, w_done, aw_hs, w_hs, ok;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_pulse;
        idx     = int'(addr) / 4;
        ok      = writable(idx);
        cyc     = 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            cyc++;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            if (!(aw_done && w_done)) begin
                checks++;
                if (bvalid !== 1'b0 || wr_pulse !== 4'b0) begin
                    errors++;
                    $display("FAIL wr_early_commit: bvalid=%b wr_pulse=%b required 0/0", bvalid, wr_pulse);
                end
                if (w_done) begin
                    checks++;
                    if (wready !== 1'b0 || awready !== 1'b1) begin
                        errors++;
                        $display("FAIL wr_have_w_ready: awready=%b wready=%b required 1/0", awready, wready);
                    end
                end
                if (aw_done) begin
                    checks++;
                    if (awready !== 1'b0 || wready !== 1'b1) begin
                        errors++;
                        $display("FAIL wr_have_aw_ready: awready=%b wready=%b required 0/1", awready, wready);
                    end
                end
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: addr=%h handshakes aw=%b w=%b required 1/1", addr, aw_done, w_done);
            return;
        end
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
            end
        end
        exp_resp  = ok ? 2'b00 : 2'b10;
        exp_pulse = ok ? (4'b0001 << idx) : 4'b0000;
        checks++;
        if (bvalid !== 1'b1 || bresp !== exp_resp) begin
            errors++;
            $display("FAIL wr_bresp: addr=%h bvalid=%b bresp=%b required 1/%b", addr, bvalid, bresp, exp_resp);
        end
        checks++;
        if (reg_out !== exp_out()) begin
            errors++;
            $display("FAIL wr_reg_out: got %h required %h", reg_out, exp_out());
        end
        checks++;
        if (wr_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL wr_pulse: got %b required %b", wr_pulse, exp_pulse);
        end
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp_ready: awready=%b wready=%b required 0/0", awready, wready);
        end
        for (int j = 0; j < b_dly; j++) begin
            tick();
            checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0
                || wr_pulse !== 4'b0) begin
                errors++;
                $display("FAIL wr_backpressure: bvalid=%b bresp=%b awready=%b wready=%b pulse=%b required 1/%b/0/0/0",
                         bvalid, bresp, awready, wready, wr_pulse, exp_resp);
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || wr_pulse !== 4'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL wr_release: bvalid=%b pulse=%b awready=%b wready=%b required 0/0/1/1",
                     bvalid, wr_pulse, awready, wready);
        end
    endtask

    task automatic read_txn(input logic [c_aw-1:0] addr, input int ar_dly, input int r_dly);
        int          cyc;
        int          idx;
        bit          done, hs;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr) / 4;
        cyc      = 0;
        done     = 1'b0;
        exp_data = '0;
        exp_resp = 2'b10;
        araddr   = addr;
        while (!done && cyc < 40) begin
            arvalid = (cyc >= ar_dly);
            hs      = arvalid && arready;
            if (hs) begin
                if (idx < c_nr) begin
                    exp_data = c_ro[idx] ? reg_in[idx*c_dw +: c_dw] : model[idx];
                    exp_resp = 2'b00;
                end else begin
                    exp_data = '0;
                    exp_resp = 2'b10;
                end
            end
            tick();
            cyc++;
            done = hs;
            if (!done) begin
                checks++;
                if (rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_early_valid: rvalid=%b required 0", rvalid);
                end
            end
        end
        arvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: addr=%h no AR handshake", addr);
            return;
        end
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: addr=%h rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/%b/0",
                     addr, rvalid, rdata, rresp, arready, exp_data, exp_resp);
        end
        for (int j = 0; j < r_dly; j++) begin
            reg_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
                errors++;
                $display("FAIL rd_backpressure: rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/%b/0",
                         rvalid, rdata, rresp, arready, exp_data, exp_resp);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_release: rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    task automatic check_all_reset(input string tag);
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 ||
            rvalid !== 1'b0 || bresp !== 2'b0 || rresp !== 2'b0 || rdata !== '0 ||
            wr_pulse !== '0 || reg_out !== '0) begin
            errors++;
            $display("FAIL %s: rdy aw/w/ar=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h pulse=%b reg_out=%h required all 0",
                     tag, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse, reg_out);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_early: aw/w/ar ready=%b%b%b required 000", awready, wready, arready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_first_edge: aw/w/ar ready=%b%b%b required 111", awready, wready, arready);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        reg_in  = '0;
        for (int i = 0; i < c_nr; i++) model[i] = '0;
        #1;
        check_all_reset("rst_immediate");
        repeat (3) @(posedge clk);
        #1;
        check_all_reset("rst_held");
        release_reset();
    endtask

    task automatic test_basic();
        for (int i = 0; i < c_nr; i++) begin
            write_txn(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < c_nr; i++) begin
            read_txn(5'(4 * i), 0, 0);
        end
    endtask

    task automatic test_w_before_aw();
        write_txn(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        checks++;
        if (reg_out[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL w_first_value: reg_out[63:32]=%h required deadbeef", reg_out[63:32]);
        end
        write_txn(5'h00, 32'h0BADF00D, 4'hF, 0, 2, 1);
        read_txn(5'h04, 1, 1);
    endtask

    task automatic test_strobes();
        write_txn(5'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        write_txn(5'h08, 32'h00000000, 4'h5, 0, 0, 0);
        checks++;
        if (reg_out[95:64] !== 32'hFF00FF00) begin
            errors++;
            $display("FAIL strobe_merge: reg_out[95:64]=%h required ff00ff00", reg_out[95:64]);
        end
        write_txn(5'h08, 32'h12345678, 4'h0, 0, 0, 0);
        read_txn(5'h0A, 0, 0);
    endtask

    task automatic test_out_of_range();
        write_txn(5'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        write_txn(5'h1C, 32'h5A5A5A5A, 4'hF, 1, 0, 0);
        read_txn(5'h10, 0, 0);
        read_txn(5'h17, 0, 1);
    endtask

    task automatic test_read_only();
        reg_in = {32'hCAFE0001, 32'h11111111, 32'h22222222, 32'h33333333};
        write_txn(5'h0C, 32'h12345678, 4'hF, 0, 0, 0);
        checks++;
        if (reg_out[127:96] !== 32'h0) begin
            errors++;
            $display("FAIL ro_reg_out: reg_out[127:96]=%h required 0", reg_out[127:96]);
        end
        read_txn(5'h0C, 0, 2);
    endtask

    task automatic test_same_edge();
        logic [31:0] old_val;
        logic [31:0] new_val;
        old_val = model[1];
        new_val = ~old_val;
        awaddr  = 5'h04;
        wdata   = new_val;
        wstrb   = 4'hF;
        araddr  = 5'h04;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        model[1] = new_val;
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_val || bvalid !== 1'b1 || reg_out[63:32] !== new_val) begin
            errors++;
            $display("FAIL same_edge: rvalid=%b rdata=%h bvalid=%b reg=%h required 1/%h/1/%h",
                     rvalid, rdata, bvalid, reg_out[63:32], old_val, new_val);
        end
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_release: rvalid=%b bvalid=%b required 0/0", rvalid, bvalid);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = cycle_cnt;
        for (int i = 0; i < 4; i++) begin
            write_txn(5'h00, $urandom, 4'hF, 0, 0, 0);
        end
        checks++;
        if (cycle_cnt - start != 8) begin
            errors++;
            $display("FAIL back_to_back: 4 writes took %0d cycles required 8", cycle_cnt - start);
        end
    endtask

    task automatic test_backpressure_reset();
        int cyc;
        write_txn(5'h00, 32'h13579BDF, 4'hF, 0, 0, 5);
        araddr  = 5'h00;
        arvalid = 1'b1;
        cyc     = 0;
        while (arready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        arvalid = 1'b0;
        tick();
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_rvalid_pending: rvalid=%b required 1", rvalid);
        end
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < c_nr; i++) model[i] = '0;
        #1;
        check_all_reset("rst_mid_read");
        rready = 1'b1;
        release_reset();
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || reg_out !== exp_out()) begin
            errors++;
            $display("FAIL rst_after_release: rvalid=%b bvalid=%b reg_out=%h required 0/0/%h",
                     rvalid, bvalid, reg_out, exp_out());
        end
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_stale_r: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            reg_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                write_txn(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                read_txn(5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle_cnt = 0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobes();
        test_out_of_range();
        test_read_only();
        test_same_edge();
        test_back_to_back();
        test_backpressure_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4lite_regbank.md
# axi4lite_regbank

Parametrised AXI4-Lite slave register bank, the next generation of the fixed four-register slave in the calculator IP. It decodes a configurable number of word-aligned registers. It supports byte strobes, AW and W arriving in either order, and per-register read-only status inputs. Out-of-range accesses receive an error response. It sits behind the AXI interconnect and gives the calculator datapath registered control outputs, per-register write pulses, and status inputs.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width; must satisfy 2^C_S_AXI_ADDR_WIDTH >= NUM_REGS*(C_S_AXI_DATA_WIDTH/8).
- NUM_REGS, 4: number of registers, 2..256.
- RO_MASK, all-zero (NUM_REGS bits): bit i = 1 makes register i read-only, sourced from reg_in.
- S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT in 3, ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data; S_AXI_WSTRB in DW/8, byte enables.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; S_AXI_ARPROT in 3, ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake.
- S_AXI_RDATA out DW, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data.
- reg_out  out  NUM_REGS*DW  flattened register contents; slice i = register i; RO slices drive 0.
- reg_in  in  NUM_REGS*DW  flattened status inputs; only RO slices used.
- wr_pulse  out  NUM_REGS  one-cycle strobe per committed write to an RW register.

## Operation
- Register index = addr[C_S_AXI_ADDR_WIDTH-1 : log2(DW/8)]; low byte-offset bits are ignored.
- Write FSM states:
  - IDLE: AWREADY=WREADY=1.
  - HAVE_AW: AW latched; AWREADY=0, WREADY=1.
  - HAVE_W: W latched; WREADY=0, AWREADY=1.
  - RESP: BVALID=1, both readies 0.
- Write FSM transitions:
  - IDLE to RESP when AW and W both handshake on the same edge.
  - IDLE to HAVE_AW or HAVE_W on a single handshake.
  - HAVE_x to RESP on the missing handshake.
  - RESP to IDLE on BVALID&&BREADY.
- Commit happens on the edge entering RESP.
  - RW, in range: byte k is updated only if WSTRB[k]=1. wr_pulse[i]=1 for the next cycle, even when WSTRB=0. BRESP=OKAY.
  - Index >= NUM_REGS or RO register: no state change, no pulse, BRESP=SLVERR (2'b10).
- Read FSM, two states:
  - R_IDLE: ARREADY=1.
  - R_VALID: RVALID=1, ARREADY=0.
  - R_IDLE to R_VALID on AR handshake; RDATA/RRESP are registered on that edge.
  - R_VALID to R_IDLE on RVALID&&RREADY.
- Read data:
  - RW: register value before the edge.
  - RO: reg_in slice sampled on the AR handshake edge.
  - Out of range: RDATA=0, RRESP=SLVERR.
- The read and write paths are independent and may be active in the same cycle.

## Timing
- Reset (ARESETN=0, immediate): all registers 0. AWREADY, WREADY, ARREADY, BVALID and RVALID are 0. BRESP, RRESP, RDATA and wr_pulse are 0. Both FSMs go to idle.
- First rising edge after ARESETN deasserts: AWREADY, WREADY and ARREADY become 1.
- Reset during any phase abandons the transaction; no B or R response is issued afterwards.
- Write latency:
  - Commit edge = the edge of the later of the AW/W handshakes.
  - reg_out, BVALID and wr_pulse change on that edge.
  - Throughput with BREADY held at 1: one write per 2 cycles.
- Read latency: RVALID is 1 in the cycle after the AR handshake. Throughput with RREADY held at 1: one read per 2 cycles.
- Backpressure:
  - BVALID, BRESP, RVALID, RDATA and RRESP are held stable until accepted.
  - No new AW/W is accepted while in RESP; no new AR is accepted while in R_VALID.
- Same-edge write commit and AR handshake to the same register: the read returns the old value.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, then write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=0xF, then read them back → each BRESP=OKAY; reads return 0x1..0x4 with RRESP=OKAY; wr_pulse[i] high exactly 1 cycle per write.
- W asserted 3 cycles before AW to 0x4, data 0xDEADBEEF → WREADY drops after the W handshake; commit and BVALID on the AW handshake edge; reg_out[63:32]=0xDEADBEEF.
- Write 0xFFFFFFFF to 0x8, then 0x00000000 with WSTRB=0x5 → register reads 0xFF00FF00.
- NUM_REGS=4, C_S_AXI_ADDR_WIDTH=5: write and read 0x10 → BRESP=SLVERR, RDATA=0, RRESP=SLVERR, no wr_pulse, registers unchanged.
- RO_MASK=4'b1000, reg_in slice 3=0xCAFE0001: write 0x12345678 to 0xC, then read 0xC → BRESP=SLVERR, read returns 0xCAFE0001, reg_out slice 3=0.
- BREADY=0 for 5 cycles after a write, and ARESETN pulsed low during a pending RVALID → BVALID and BRESP stable, AWREADY=0 throughout; after reset RVALID=0, registers 0, ARREADY=1 on the first edge after release.
